// File: rtl/dma_wr_arbiter.sv
// dma_wr_arbiter: shares one AXI4 write master between the crypto DMA writeback
// (port 0) and the S2MM engine (port 1). Only one burst is in flight at a time.
// The owner is chosen in IDLE and keeps the channel through AW, every W beat
// and B. A sticky err_len flags W beat counts that disagree with AWLEN.
// Optional build macro DMA_WR_ARB_STATS_EN adds saturating grant/stall counters.
module dma_wr_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // port 0: crypto DMA writeback
  input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic [LEN_WIDTH-1:0]    s0_awlen,
  input  logic [2:0]              s0_awsize,
  input  logic [1:0]              s0_awburst,
  input  logic                    s0_awvalid,
  output logic                    s0_awready,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  input  logic                    s0_wlast,
  input  logic                    s0_wvalid,
  output logic                    s0_wready,
  output logic [1:0]              s0_bresp,
  output logic                    s0_bvalid,
  input  logic                    s0_bready,
  // port 1: S2MM engine
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic [LEN_WIDTH-1:0]    s1_awlen,
  input  logic [2:0]              s1_awsize,
  input  logic [1:0]              s1_awburst,
  input  logic                    s1_awvalid,
  output logic                    s1_awready,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                    s1_wlast,
  input  logic                    s1_wvalid,
  output logic                    s1_wready,
  output logic [1:0]              s1_bresp,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  // shared master toward DDR
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [LEN_WIDTH-1:0]    m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  // control / status
  input  logic                    cfg_fixed_prio,
  input  logic                    err_clr,
  output logic [1:0]              grant,
  output logic                    busy,
  output logic                    err_len
`ifdef DMA_WR_ARB_STATS_EN
  ,
  output logic [31:0]             stat_grants0,
  output logic [31:0]             stat_grants1,
  output logic [31:0]             stat_stall
`endif
);

  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t               state;
  logic                 rr_ptr;   // preferred port on a tie in round-robin mode
  logic [LEN_WIDTH-1:0] len_q;
  logic [CW-1:0]        cnt;
  logic [1:0]           req;
  logic [1:0]           pick;
  logic                 sel;
  logic                 aw_hs, w_hs, b_hs;
  logic                 err_set;
  logic [1:0]           awready_v, wready_v, bvalid_v;

  assign req   = {s1_awvalid, s0_awvalid};
  assign sel   = grant[1];
  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;
  assign b_hs  = m_bvalid & m_bready;

  assign s0_awready = awready_v[0];
  assign s1_awready = awready_v[1];
  assign s0_wready  = wready_v[0];
  assign s1_wready  = wready_v[1];
  assign s0_bvalid  = bvalid_v[0];
  assign s1_bvalid  = bvalid_v[1];

  // Arbitration: a lone requester wins; ties go to port 0 in fixed mode, else to rr_ptr.
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = (cfg_fixed_prio || !rr_ptr) ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  // Channel routing: payload follows the owner, handshakes are gated by the current phase.
  always_comb begin
    m_awaddr  = sel ? s1_awaddr  : s0_awaddr;
    m_awlen   = sel ? s1_awlen   : s0_awlen;
    m_awsize  = sel ? s1_awsize  : s0_awsize;
    m_awburst = sel ? s1_awburst : s0_awburst;
    m_wdata   = sel ? s1_wdata   : s0_wdata;
    m_wstrb   = sel ? s1_wstrb   : s0_wstrb;
    m_wlast   = sel ? s1_wlast   : s0_wlast;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    awready_v = 2'b00;
    wready_v  = 2'b00;
    bvalid_v  = 2'b00;
    s0_bresp  = 2'b00;
    s1_bresp  = 2'b00;
    case (state)
      S_AW: begin
        m_awvalid      = sel ? s1_awvalid : s0_awvalid;
        awready_v[sel] = m_awready;
      end
      S_W: begin
        m_wvalid      = sel ? s1_wvalid : s0_wvalid;
        wready_v[sel] = m_wready;
      end
      S_B: begin
        m_bready      = sel ? s1_bready : s0_bready;
        bvalid_v[sel] = m_bvalid;
        if (sel) s1_bresp = m_bresp;
        else     s0_bresp = m_bresp;
      end
      default: ;
    endcase
  end

  // Burst sequencer: owns grant/busy, latches AWLEN and counts W beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      grant  <= 2'b00;
      busy   <= 1'b0;
      rr_ptr <= 1'b0;
      len_q  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant <= pick;
            busy  <= 1'b1;
            state <= S_AW;
          end
        end
        S_AW: begin
          if (aw_hs) begin
            len_q <= m_awlen;
            cnt   <= '0;
            state <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            // saturate so an over-long burst can never wrap back onto awlen
            if (cnt != {CW{1'b1}}) cnt <= cnt + {{LEN_WIDTH{1'b0}}, 1'b1};
            if (m_wlast) state <= S_B;
          end
        end
        S_B: begin
          if (b_hs) begin
            rr_ptr <= grant[0];   // the other port is preferred next time
            grant  <= 2'b00;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Mismatch when exactly one of "wlast" and "count reached awlen" holds on a beat.
  assign err_set = (state == S_W) && w_hs && (m_wlast ^ (cnt == {1'b0, len_q}));

  // Sticky length error; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_len <= 1'b0;
    else if (err_set) err_len <= 1'b1;
    else if (err_clr) err_len <= 1'b0;
  end

`ifdef DMA_WR_ARB_STATS_EN
  // Saturating per-port completion counters and W back-pressure counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants0 <= '0;
      stat_grants1 <= '0;
      stat_stall   <= '0;
    end else if (err_clr) begin
      stat_grants0 <= '0;
      stat_grants1 <= '0;
      stat_stall   <= '0;
    end else begin
      if (b_hs && grant[0] && stat_grants0 != 32'hFFFF_FFFF) stat_grants0 <= stat_grants0 + 32'd1;
      if (b_hs && grant[1] && stat_grants1 != 32'hFFFF_FFFF) stat_grants1 <= stat_grants1 + 32'd1;
      if (m_wvalid && !m_wready && stat_stall != 32'hFFFF_FFFF) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_wr_arbiter.sv
// Directed bench for dma_wr_arbiter: a small requester/DDR model advanced one
// cycle at a time from the main sequence; all values are driven and sampled
// on the falling edge.
module tb_dma_wr_arbiter;
  localparam int AW = 32, DW = 32, LW = 8, SW = DW/8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] awaddr [2];
  logic [LW-1:0] awlen  [2];
  logic [2:0]    awsize [2];
  logic [1:0]    awburst[2];
  logic          awvalid[2], awready[2];
  logic [DW-1:0] wdata  [2];
  logic [SW-1:0] wstrb  [2];
  logic          wlast  [2], wvalid[2], wready[2];
  logic [1:0]    bresp  [2];
  logic          bvalid [2], bready[2];

  logic [AW-1:0] m_awaddr;
  logic [LW-1:0] m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic          m_awvalid, m_awready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_wlast, m_wvalid, m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid, m_bready;
  logic          cfg_fixed_prio, err_clr;
  logic [1:0]    grant;
  logic          busy, err_len;
`ifdef DMA_WR_ARB_STATS_EN
  logic [31:0]   stat_grants0, stat_grants1, stat_stall;
`endif

  dma_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_awaddr(awaddr[0]), .s0_awlen(awlen[0]), .s0_awsize(awsize[0]), .s0_awburst(awburst[0]),
    .s0_awvalid(awvalid[0]), .s0_awready(awready[0]),
    .s0_wdata(wdata[0]), .s0_wstrb(wstrb[0]), .s0_wlast(wlast[0]),
    .s0_wvalid(wvalid[0]), .s0_wready(wready[0]),
    .s0_bresp(bresp[0]), .s0_bvalid(bvalid[0]), .s0_bready(bready[0]),
    .s1_awaddr(awaddr[1]), .s1_awlen(awlen[1]), .s1_awsize(awsize[1]), .s1_awburst(awburst[1]),
    .s1_awvalid(awvalid[1]), .s1_awready(awready[1]),
    .s1_wdata(wdata[1]), .s1_wstrb(wstrb[1]), .s1_wlast(wlast[1]),
    .s1_wvalid(wvalid[1]), .s1_wready(wready[1]),
    .s1_bresp(bresp[1]), .s1_bvalid(bvalid[1]), .s1_bready(bready[1]),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .cfg_fixed_prio(cfg_fixed_prio), .err_clr(err_clr),
    .grant(grant), .busy(busy), .err_len(err_len)
`ifdef DMA_WR_ARB_STATS_EN
    , .stat_grants0(stat_grants0), .stat_grants1(stat_grants1), .stat_stall(stat_stall)
`endif
  );

  int checks = 0, failures = 0;

  // requester jobs
  int            nb[2], nbeats[2], bi[2], bcnt[2];
  logic [31:0]   base[2];
  logic [AW-1:0] jaddr[2];
  logic [LW-1:0] jlen[2];
  logic [1:0]    lresp[2];
  int            border[$];
  // DDR-side log
  logic [DW-1:0] mdata[$];
  bit            mlast[$];
  logic [AW-1:0] cap_addr;
  logic [LW-1:0] cap_len;
  int            route_err, stall_left;
  bit            clr_on_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int p);
    awvalid[p] = 1'b1; awaddr[p] = jaddr[p]; awlen[p] = jlen[p];
    awsize[p] = 3'd2; awburst[p] = 2'd1;
    wvalid[p] = 1'b1; wdata[p] = base[p]; wstrb[p] = '1;
    wlast[p] = (nbeats[p] == 1); bi[p] = 0;
  endtask

  task automatic start(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l,
                       input int beats, input logic [31:0] b, input int n);
    jaddr[p] = a; jlen[p] = l; nbeats[p] = beats; base[p] = b; nb[p] = n;
    load(p);
  endtask

  task automatic clear_logs();
    mdata.delete(); mlast.delete(); border.delete();
    bcnt[0] = 0; bcnt[1] = 0; route_err = 0;
    cap_addr = '0; cap_len = '0;
  endtask

  // One clock cycle: decide DDR inputs, sample handshakes, cross the edge, update models.
  task automatic tick();
    bit awh[2], wh[2], bh[2];
    bit mw, ml, mb;
    if (stall_left > 0 && m_wvalid) begin m_wready = 1'b0; stall_left--; end
    else m_wready = 1'b1;
    if (clr_on_last) err_clr = m_wvalid && m_wlast;
    #1;
    for (int p = 0; p < 2; p++) begin
      awh[p] = awvalid[p] && awready[p];
      wh[p]  = wvalid[p] && wready[p];
      bh[p]  = bvalid[p] && bready[p];
      if (!grant[p] && (awready[p] || wready[p] || bvalid[p])) route_err++;
      if (bh[p]) lresp[p] = bresp[p];
    end
    mw = m_wvalid && m_wready;
    ml = m_wlast;
    mb = m_bvalid && m_bready;
    if (mw) begin mdata.push_back(m_wdata); mlast.push_back(m_wlast); end
    if (m_awvalid && m_awready) begin cap_addr = m_awaddr; cap_len = m_awlen; end
    @(negedge clk);
    if (mb) m_bvalid = 1'b0;
    if (mw && ml) m_bvalid = 1'b1;
    for (int p = 0; p < 2; p++) begin
      if (awh[p]) awvalid[p] = 1'b0;
      if (wh[p]) begin
        bi[p]++;
        if (bi[p] == nbeats[p]) begin wvalid[p] = 1'b0; wlast[p] = 1'b0; end
        else begin wdata[p] = base[p] + bi[p]; wlast[p] = (bi[p] == nbeats[p] - 1); end
      end
      if (bh[p]) begin
        bcnt[p]++; border.push_back(p); nb[p]--;
        if (nb[p] > 0) load(p);
      end
    end
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while (!(nb[0] == 0 && nb[1] == 0 && !busy) && n < budget) begin tick(); n++; end
    chk(tag, 64'(n < budget), 64'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      awaddr[p] = '0; awlen[p] = '0; awsize[p] = '0; awburst[p] = '0; awvalid[p] = 1'b0;
      wdata[p] = '0; wstrb[p] = '0; wlast[p] = 1'b0; wvalid[p] = 1'b0; bready[p] = 1'b1;
      nb[p] = 0; nbeats[p] = 1; bi[p] = 0; lresp[p] = 2'b11;
    end
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
    cfg_fixed_prio = 1'b0; err_clr = 1'b0; stall_left = 0; clr_on_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  logic [7:0] lmask;

  initial begin
    // ---- reset state
    do_reset();
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy_err", 64'({busy, err_len}), 64'(0));
    chk("rst_m_valids", 64'({m_awvalid, m_wvalid, m_bready}), 64'(0));
    chk("rst_s_readies", 64'({awready[0], awready[1], wready[0], wready[1], bvalid[0], bvalid[1]}), 64'(0));
`ifdef DMA_WR_ARB_STATS_EN
    chk("rst_stats", 64'(stat_grants0 | stat_grants1 | stat_stall), 64'(0));
`endif

    // ---- port 0, 8-beat burst
    start(0, 32'h2000_0000, 8'd7, 8, 32'hDEAD_CAFE, 1);
    #1;
    chk("t1_lat_awvalid0", 64'({m_awvalid, grant}), 64'(0));
    chk("t1_w_stall_idle", 64'(wready[0]), 64'(0));
    tick();
    #1;
    chk("t1_grant", 64'(grant), 64'(2'b01));
    chk("t1_awvalid_busy", 64'({m_awvalid, busy}), 64'(2'b11));
    chk("t1_w_stall_aw", 64'(wready[0]), 64'(0));
    run_idle("t1_timeout", 100);
    chk("t1_awaddr", 64'(cap_addr), 64'(32'h2000_0000));
    chk("t1_awlen", 64'(cap_len), 64'(7));
    chk("t1_nbeats", 64'(mdata.size()), 64'(8));
    lmask = '0;
    for (int i = 0; i < 8 && i < mdata.size(); i++) begin
      chk("t1_beat", 64'(mdata[i]), 64'(32'hDEAD_CAFE + i));
      lmask[i] = mlast[i];
    end
    chk("t1_wlast_mask", 64'(lmask), 64'(8'h80));
    chk("t1_bcnt", 64'({bcnt[0][7:0], bcnt[1][7:0]}), 64'(16'h0100));
    chk("t1_bresp", 64'(lresp[0]), 64'(0));
    chk("t1_route", 64'(route_err), 64'(0));
    chk("t1_grant_idle", 64'(grant), 64'(0));
    chk("t1_err", 64'(err_len), 64'(0));

    // ---- boundaries: awlen=0 single beat, awlen=255 full burst
    clear_logs();
    start(1, 32'h0000_3000, 8'd0, 1, 32'h1111_0000, 1);
    run_idle("t2a_timeout", 50);
    chk("t2a_nbeats", 64'(mdata.size()), 64'(1));
    if (mdata.size() == 1) chk("t2a_beat", 64'({mlast[0], mdata[0]}), {31'd0, 1'b1, 32'h1111_0000});
    chk("t2a_err", 64'(err_len), 64'(0));
    clear_logs();
    start(0, 32'h0000_4000, 8'd255, 256, 32'h5000_0000, 1);
    run_idle("t2b_timeout", 400);
    chk("t2b_awlen", 64'(cap_len), 64'(255));
    chk("t2b_nbeats", 64'(mdata.size()), 64'(256));
    if (mdata.size() == 256) chk("t2b_last_beat", 64'({mlast[255], mdata[255]}), {31'd0, 1'b1, 32'h5000_00FF});
    chk("t2b_err", 64'(err_len), 64'(0));

    // ---- round-robin with simultaneous requests
    do_reset();
    start(0, 32'h100, 8'd0, 1, 32'hA000_0000, 3);
    start(1, 32'h200, 8'd0, 1, 32'hB000_0000, 3);
    run_idle("t3_timeout", 100);
    chk("t3_count", 64'(border.size()), 64'(6));
    for (int i = 0; i < 6 && i < border.size(); i++) chk("t3_order", 64'(border[i]), 64'(i % 2));
    chk("t3_route", 64'(route_err), 64'(0));

    // ---- fixed priority starves port 1 until round-robin is restored
    clear_logs();
    cfg_fixed_prio = 1'b1;
    start(0, 32'h300, 8'd0, 1, 32'hC000_0000, 100);
    start(1, 32'h400, 8'd0, 1, 32'hD000_0000, 1);
    for (int n = 0; n < 100 && bcnt[0] < 3; n++) tick();
    chk("t4_p0_three", 64'(bcnt[0]), 64'(3));
    chk("t4_p1_starved", 64'(bcnt[1]), 64'(0));
    cfg_fixed_prio = 1'b0;
    for (int n = 0; n < 100 && bcnt[1] < 1; n++) tick();
    chk("t4_p1_granted", 64'(bcnt[1]), 64'(1));
    chk("t4_p1_next", 64'(bcnt[0]), 64'(3));
    nb[0] = 1;
    run_idle("t4_timeout", 100);
    chk("t4_p0_final", 64'(bcnt[0]), 64'(4));

    // ---- early wlast, clear, set-wins-over-clear, late wlast
    clear_logs();
    start(1, 32'h6000, 8'd3, 2, 32'hA0A0_0000, 1);
    run_idle("t5a_timeout", 50);
    chk("t5a_nbeats", 64'(mdata.size()), 64'(2));
    chk("t5a_bcnt", 64'(bcnt[1]), 64'(1));
    chk("t5a_err_set", 64'(err_len), 64'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("t5a_err_clr", 64'(err_len), 64'(0));
    clr_on_last = 1'b1;
    start(1, 32'h6100, 8'd3, 2, 32'hA1A1_0000, 1);
    run_idle("t5b_timeout", 50);
    clr_on_last = 1'b0;
    err_clr = 1'b0;
    #1;
    chk("t5b_set_wins", 64'(err_len), 64'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    clear_logs();
    start(0, 32'h6200, 8'd0, 2, 32'hA2A2_0000, 1);
    run_idle("t5c_timeout", 50);
    chk("t5c_nbeats", 64'(mdata.size()), 64'(2));
    chk("t5c_err_long", 64'(err_len), 64'(1));

    // ---- reset mid-burst, then port 1 first
    do_reset();
    start(0, 32'h7000, 8'd7, 8, 32'hBEEF_0000, 1);
    for (int n = 0; n < 20 && mdata.size() < 2; n++) tick();
    #1;
    chk("t6_beat3_presented", 64'({m_wvalid, m_wdata}), {31'd0, 1'b1, 32'hBEEF_0002});
    rst_n = 1'b0;
    #1;
    chk("t6_rst_m", 64'({m_awvalid, m_wvalid, m_bready}), 64'(0));
    chk("t6_rst_s", 64'({awready[0], awready[1], wready[0], wready[1], bvalid[0], bvalid[1]}), 64'(0));
    chk("t6_rst_status", 64'({grant, busy, err_len}), 64'(0));
    for (int p = 0; p < 2; p++) begin awvalid[p] = 1'b0; wvalid[p] = 1'b0; nb[p] = 0; end
    m_bvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    start(1, 32'h8000, 8'd0, 1, 32'hCAFE_0000, 1);
    tick();
    #1;
    chk("t6_p1_first", 64'(grant), 64'(2'b10));
    run_idle("t6_timeout", 50);
    chk("t6_bcnt", 64'({bcnt[0][7:0], bcnt[1][7:0]}), 64'(16'h0001));
    chk("t6_nbeats", 64'(mdata.size()), 64'(1));

`ifdef DMA_WR_ARB_STATS_EN
    // ---- statistics
    do_reset();
    start(0, 32'h9000, 8'd3, 4, 32'h9000_0000, 2);
    start(1, 32'h9100, 8'd3, 4, 32'h9100_0000, 1);
    stall_left = 5;
    run_idle("t7_timeout", 200);
    chk("t7_grants0", 64'(stat_grants0), 64'(2));
    chk("t7_grants1", 64'(stat_grants1), 64'(1));
    chk("t7_stall", 64'(stat_stall), 64'(5));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("t7_clr", 64'(stat_grants0 | stat_grants1 | stat_stall), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard stop so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dma_wr_arbiter.md
Name: dma_wr_arbiter

Overview:
- Shares the single AXI4 write master (DDR) between two write requesters: port 0 is the crypto DMA writeback and port 1 is the S2MM engine.
- Sits between those engines and the `m_axis_*` write channel of `crypto_dma_subsystem`.
- Grants one whole burst at a time (AW, then all W beats, then B), with round-robin or fixed priority.
- Checks that the W beat count matches AWLEN and flags a sticky error on mismatch.

Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; WSTRB width is DATA_WIDTH/8
- LEN_WIDTH, 8, AWLEN width; the beat counter is LEN_WIDTH+1 bits

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- sN_awaddr (N=0,1)  input  ADDR_WIDTH  requester write address
- sN_awlen  input  LEN_WIDTH  requester burst length minus 1
- sN_awsize / sN_awburst  input  3 / 2  requester size and burst type
- sN_awvalid  input  1 / sN_awready  output  1  requester AW handshake
- sN_wdata  input  DATA_WIDTH / sN_wstrb  input  DATA_WIDTH/8 / sN_wlast  input  1  requester write data
- sN_wvalid  input  1 / sN_wready  output  1  requester W handshake
- sN_bresp  output  2 / sN_bvalid  output  1 / sN_bready  input  1  requester write response
- m_awaddr, m_awlen, m_awsize, m_awburst  output  (as above)  to DDR
- m_awvalid  output  1 / m_awready  input  1  DDR AW handshake
- m_wdata, m_wstrb, m_wlast  output  (as above)  to DDR
- m_wvalid  output  1 / m_wready  input  1  DDR W handshake
- m_bresp  input  2 / m_bvalid  input  1 / m_bready  output  1  DDR write response
- cfg_fixed_prio  input  1  1 = port 0 always wins; 0 = round-robin
- err_clr  input  1  one-cycle pulse clears err_len
- grant  output  2  one-hot owner; 00 when idle
- busy  output  1  high in any state other than IDLE
- err_len  output  1  sticky beat-count mismatch flag

Behaviour:

Reset:
- All valid and ready outputs, grant, busy and err_len are 0.
- State is IDLE, the round-robin pointer points at port 0, and the beat counter is 0.
- Assertion mid-burst aborts immediately, with no completion of the burst.

State machine — IDLE → AW → W → B → IDLE, one outstanding burst only:
- IDLE:
  - Samples s0_awvalid and s1_awvalid.
  - One requesting → grant it.
  - Both requesting, fixed priority → port 0.
  - Both requesting, round-robin → the port not granted last.
  - Grant is registered, so m_awvalid rises 1 cycle after sN_awvalid (latency 1).
- AW:
  - m_aw* follows the selected port combinationally.
  - s_sel_awready = m_awready.
  - On handshake, latch awlen, clear the beat counter, go to W.
- W:
  - m_w* follows the selected port.
  - s_sel_wready = m_wready.
  - Each handshake increments the counter.
  - On the handshake with wlast=1, go to B.
- B:
  - m_bready = s_sel_bready; s_sel_bvalid = m_bvalid; s_sel_bresp = m_bresp.
  - On handshake, record the last grant and go to IDLE.
  - A new grant is possible the next cycle.

Signal routing:
- The non-granted port sees awready, wready and bvalid all 0.
- m_* valids are 0 outside their own state.
- W beats presented before the AW handshake are stalled (wready=0).

Length check:
- Fires on the beat that has wlast=1, or on the beat whose count equals the latched awlen.
- If exactly one of those two conditions holds on that beat, set err_len.
- Termination always follows wlast.
- err_clr clears err_len; if err_clr and a new error occur in the same cycle, set wins.

Boundary conditions:
- awlen=0 is a single-beat burst.
- awlen=255 needs the counter to reach 255 without overflow, which the 9-bit counter guarantees.
- cfg_fixed_prio changes take effect at the next IDLE arbitration only.
- sN_awvalid dropping while in AW is not AXI-legal and is not handled.

Optional Feature:
- Macro: DMA_WR_ARB_STATS_EN.
- When defined, adds outputs `stat_grants0` and `stat_grants1` (32 bits each, saturating) and `stat_stall` (32 bits, saturating).
  - `stat_grantsN` counts completed B handshakes per port.
  - `stat_stall` counts cycles with m_wvalid=1 and m_wready=0.
  - All three reset to 0 and are cleared by err_clr.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Port 0 only, awaddr=0x2000_0000, awlen=7, 8 beats 0xDEADCAFE+i → m sees the same 8 beats with wlast on beat 8; B with OKAY is routed to s0 only; grant returns to 00.
- Both request in the same cycle, round-robin, three bursts each with awlen=0 → grant order 01,10,01,10,01,10.
- Both request, cfg_fixed_prio=1, s0 requests continuously → s1 never granted; after cfg_fixed_prio=0, s1 is granted at the next IDLE.
- Port 1 awlen=3, wlast on beat 2 → burst ends after 2 beats and err_len=1; err_clr pulse → err_len=0.
- rst_n low during W beat 3 of 8 → all valids and readies are 0 asynchronously; after release, port 1 is granted first.
- With DMA_WR_ARB_STATS_EN: two s0 bursts, one s1 burst, m_wready held low for 5 cycles → stat_grants0=2, stat_grants1=1, stat_stall=5.
